mult_booth_ctrl: RTL and testbench



---
 rtl/mult_booth_ctrl_if.sv | 22 ++
 rtl/mult_booth_ctrl.sv | 100 ++++++++++
 tb/tb_mult_booth_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/mult_booth_ctrl_if.sv
// Start/operand and result/status bundle between a requester and the Booth multiplier.
interface mult_booth_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             ctrl_MULT;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;

  modport master (
    output ctrl_MULT, data_operandA, data_operandB,
    input  data_result, data_exception, data_resultRDY, busy
  );

  modport slave (
    input  ctrl_MULT, data_operandA, data_operandB,
    output data_result, data_exception, data_resultRDY, busy
  );
endinterface

// File: rtl/mult_booth_ctrl.sv
// Radix-4 Booth sequential signed multiplier: one adder reused over WIDTH/2 steps.
// Start at edge k gives a one-cycle RDY after edge k+WIDTH/2; a new start always restarts.
module mult_booth_ctrl #(
  parameter int WIDTH = 32
) (
  input logic              clock,
  input logic              reset,
  mult_booth_ctrl_if.slave bus
);
  localparam int STEPS = WIDTH / 2;
  localparam int PW    = 2 * WIDTH + 3;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             exc_q, exc_d;

  logic [WIDTH+1:0] a_ext;
  logic [WIDTH+1:0] addend;
  logic [WIDTH+1:0] upper_sum;
  logic [PW-1:0]    prod_step;
  logic [WIDTH:0]   hi_bits;
  logic             last_step;

  // Product register layout: {upper[WIDTH+1:0], lower[WIDTH-1:0], q_-1}.
  always_comb begin
    a_ext = {{2{mcand_q[WIDTH-1]}}, mcand_q};
    addend = '0;
    case (prod_q[2:0])
      3'b001, 3'b010: addend = a_ext;
      3'b011:         addend = a_ext << 1;
      3'b100:         addend = -(a_ext << 1);
      3'b101, 3'b110: addend = -a_ext;
      default:        addend = '0;
    endcase
    upper_sum = prod_q[PW-1:WIDTH+1] + addend;
    prod_step = $signed({upper_sum, prod_q[WIDTH:0]}) >>> 2;
    // Product bit i sits at prod_step[i+1] after the final shift.
    hi_bits   = prod_step[2*WIDTH:WIDTH];
    last_step = (cnt_q == CW'(STEPS - 1));
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    prod_d   = prod_q;
    result_d = result_q;
    exc_d    = exc_q;
    if (bus.ctrl_MULT) begin
      state_d = RUN;
      cnt_d   = '0;
      mcand_d = bus.data_operandA;
      prod_d  = {{(WIDTH + 2){1'b0}}, bus.data_operandB, 1'b0};
    end else begin
      case (state_q)
        RUN: begin
          prod_d = prod_step;
          cnt_d  = cnt_q + CW'(1);
          if (last_step) begin
            state_d  = DONE;
            cnt_d    = '0;
            result_d = prod_step[WIDTH:1];
            exc_d    = (|hi_bits) && !(&hi_bits);
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      prod_q   <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      result_q <= result_d;
      exc_q    <= exc_d;
    end
  end

  assign bus.data_result    = result_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = (state_q == DONE);
  assign bus.busy           = (state_q == RUN);
endmodule

// File: tb/tb_mult_booth_ctrl.sv
// Randomized and directed checks of mult_booth_ctrl against a product-level reference model.
module tb_mult_booth_ctrl;
  localparam int W     = 32;
  localparam int STEPS = W / 2;

  logic clock = 1'b0;
  logic reset = 1'b1;

  mult_booth_ctrl_if #(.WIDTH(W)) bus ();

  mult_booth_ctrl #(.WIDTH(W)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int n_chk   = 0;
  int n_err   = 0;
  int rdy_cnt = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [2*W-1:0] mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [2*W-1:0] sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    return sa * sb;
  endfunction

  function automatic bit ovf(input logic [2*W-1:0] p);
    logic signed [2*W-1:0] t;
    t = $signed(p[W-1:0]);
    return (t != p);
  endfunction

  // Reference: each start captures the exact product; it is reported STEPS edges later unless restarted.
  logic [2*W-1:0] m_prod = '0;
  int             m_left = 0;
  bit             m_busy = 1'b0;
  bit             m_rdy  = 1'b0;
  bit             m_exc  = 1'b0;
  logic [W-1:0]   m_res  = '0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_prod = '0; m_left = 0; m_busy = 0; m_rdy = 0; m_exc = 0; m_res = '0;
    end else begin
      m_rdy = 1'b0;
      if (bus.ctrl_MULT) begin
        m_prod = mul(bus.data_operandA, bus.data_operandB);
        m_left = STEPS;
        m_busy = 1'b1;
      end else if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0;
          m_rdy  = 1'b1;
          m_res  = m_prod[W-1:0];
          m_exc  = ovf(m_prod);
        end
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("busy", {63'b0, bus.busy}, {63'b0, m_busy});
      chk("rdy", {63'b0, bus.data_resultRDY}, {63'b0, m_rdy});
      chk("result", {32'b0, bus.data_result}, {32'b0, m_res});
      chk("exception", {63'b0, bus.data_exception}, {63'b0, m_exc});
    end
  end

  always @(posedge clock) begin
    if (bus.data_resultRDY) rdy_cnt++;
  end

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    bus.ctrl_MULT     = 1'b1;
    bus.data_operandA = a;
    bus.data_operandB = b;
    @(negedge clock);
    bus.ctrl_MULT     = 1'b0;
    bus.data_operandA = $urandom;
    bus.data_operandB = $urandom;
  endtask

  task automatic wait_rdy(output int n);
    n = 1;
    while (!bus.data_resultRDY && n < 60) begin
      @(negedge clock);
      n++;
    end
  endtask

  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_r, input bit exp_e);
    int n;
    repeat (2) @(negedge clock);
    start_op(a, b);
    wait_rdy(n);
    chk({name, "_latency"}, 64'(n), 64'(STEPS + 1));
    chk({name, "_result"}, {32'b0, bus.data_result}, {32'b0, exp_r});
    chk({name, "_exc"}, {63'b0, bus.data_exception}, {63'b0, exp_e});
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h8000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'hFFFF_FFFF;
      3:       return W'($urandom_range(0, 31)) - W'(16);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    int c0;
    bus.ctrl_MULT     = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    repeat (2) @(negedge clock);
    reset  = 1'b0;
    chk_en = 1'b1;
    chk("reset_result", {32'b0, bus.data_result}, 64'h0);
    chk("reset_busy", {63'b0, bus.busy}, 64'h0);
    chk("reset_rdy", {63'b0, bus.data_resultRDY}, 64'h0);

    run_op("3x5", 32'd3, 32'd5, 32'h0000_000F, 1'b0);
    run_op("m7x6", 32'hFFFF_FFF9, 32'd6, 32'hFFFF_FFD6, 1'b0);
    run_op("m1xm1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    run_op("maxx2", 32'h7FFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b1);
    run_op("minxm1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    run_op("minx1", 32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0);

    // Restart halfway through: only the second operation reports.
    repeat (2) @(negedge clock);
    c0 = rdy_cnt;
    start_op(32'd3, 32'd5);
    repeat (7) @(negedge clock);
    start_op(32'd10, 32'd10);
    wait_rdy(n);
    chk("restart_latency", 64'(n), 64'(STEPS + 1));
    chk("restart_no_early_rdy", 64'(rdy_cnt), 64'(c0));
    chk("restart_result", {32'b0, bus.data_result}, 64'h64);

    // Start held for three cycles: the last operands win.
    repeat (2) @(negedge clock);
    c0 = rdy_cnt;
    for (int i = 0; i < 3; i++) begin
      bus.ctrl_MULT     = 1'b1;
      bus.data_operandA = W'(i + 4);
      bus.data_operandB = W'(i + 5);
      @(negedge clock);
    end
    bus.ctrl_MULT = 1'b0;
    wait_rdy(n);
    chk("held_latency", 64'(n), 64'(STEPS + 1));
    chk("held_no_early_rdy", 64'(rdy_cnt), 64'(c0));
    chk("held_result", {32'b0, bus.data_result}, 64'd42);

    // Asynchronous reset in the middle of a run.
    repeat (2) @(negedge clock);
    start_op(32'd3, 32'd5);
    repeat (5) @(negedge clock);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    chk("arst_result", {32'b0, bus.data_result}, 64'h0);
    chk("arst_busy", {63'b0, bus.busy}, 64'h0);
    chk("arst_exc", {63'b0, bus.data_exception}, 64'h0);
    chk("arst_rdy", {63'b0, bus.data_resultRDY}, 64'h0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    c0 = rdy_cnt;
    repeat (25) @(negedge clock);
    chk("arst_no_rdy", 64'(rdy_cnt), 64'(c0));
    run_op("4x4", 32'd4, 32'd4, 32'h0000_0010, 1'b0);

    // Back-to-back: new start issued during the DONE cycle.
    repeat (2) @(negedge clock);
    c0 = rdy_cnt;
    start_op(32'd3, 32'd5);
    wait_rdy(n);
    chk("b2b_first_result", {32'b0, bus.data_result}, 64'h0F);
    start_op(32'd2, 32'd2);
    wait_rdy(n);
    chk("b2b_second_latency", 64'(n), 64'(STEPS + 1));
    chk("b2b_second_result", {32'b0, bus.data_result}, 64'h4);
    repeat (20) @(negedge clock);
    chk("b2b_pulse_count", 64'(rdy_cnt - c0), 64'd2);

    for (int i = 0; i < 4000; i++) begin
      bus.ctrl_MULT     = ($urandom_range(0, 24) == 0);
      bus.data_operandA = pick();
      bus.data_operandB = pick();
      @(negedge clock);
    end
    bus.ctrl_MULT = 1'b0;
    repeat (25) @(negedge clock);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    n_err++;
    $display("FAIL watchdog: simulation did not finish, time %0t, expected below 2000000", $time);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
